// File: rtl/fifo_read_streamer_if.sv
// FIFO read-side and valid/ready stream signals for the FIFO drain stage.
// master = streamer, slave = FIFO plus downstream sink.
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en, m_valid, m_data,
    input  fifo_dout, fifo_empty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data,
    output fifo_dout, fifo_empty, fifo_underflow, m_ready
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// Drains a synchronous FIFO with one-cycle read latency onto a valid/ready stream
// through a 2-entry buffer, counting delivered words and flagged underflows.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_read_streamer_if.master  bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  underflow_cnt
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic                  push;
  logic                  rd_en;
  logic [2:0]            level;
  logic [1:0]            wr_slot;

  always_comb begin
    pop   = (occ != 2'd0) & bus.m_ready;
    push  = inflight & ~bus.fifo_underflow;
    // Credit: words that will occupy the buffer after this cycle's pop.
    level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    rd_en = enable & ~bus.fifo_empty & ~rst & (level < 3'd2);
    // Slot the returning word lands in once this cycle's pop has shifted the buffer.
    wr_slot = occ - {1'b0, pop};
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = head;
  assign busy           = inflight | (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
      word_cnt      <= '0;
      underflow_cnt <= '0;
    end else begin
      inflight <= rd_en;
      occ      <= occ + {1'b0, push} - {1'b0, pop};

      if (push && wr_slot == 2'd0)
        head <= bus.fifo_dout;
      else if (pop && occ == 2'd2)
        head <= tail;

      if (push && wr_slot == 2'd1)
        tail <= bus.fifo_dout;

      if (pop && word_cnt != '1)
        word_cnt <= word_cnt + 1'b1;

      if (inflight && bus.fifo_underflow && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench: a behavioural FIFO feeds the streamer, expected words are queued at load
// time and a negedge monitor checks order and stream stability on every handshake.
module tb_fifo_read_streamer;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          busy;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] underflow_cnt;

  fifo_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_read_streamer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bus           (bus.master),
    .busy          (busy),
    .word_cnt      (word_cnt),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO: registered read data, underflow flag forced on one chosen read index.
  logic [DW-1:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  int uf_idx = -1;

  assign bus.fifo_empty = (wp == rp);

  initial begin
    bus.fifo_dout      = '0;
    bus.fifo_underflow = 1'b0;
    bus.m_ready        = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout      <= mem[rp];
      bus.fifo_underflow <= (rp == uf_idx);
      rp                 <= rp + 1;
    end else begin
      bus.fifo_underflow <= 1'b0;
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: in-order data against the scoreboard, and hold-while-stalled rule.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, bus.m_valid}, 32'd1);
        check("stall_data_held", {16'd0, bus.m_data}, {16'd0, prev_data});
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", bus.m_data, $time);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            errors++;
            $display("FAIL word_order: got 0x%0h expected 0x%0h at %0t", bus.m_data, e, $time);
          end
        end
      end
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic drive_slot;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input bit expect_out);
    mem[wp] = d;
    wp++;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic do_reset;
    drive_slot();
    rst = 1'b1;
    enable = 1'b0;
    bus.m_ready = 1'b0;
    uf_idx = -1;
    drive_slot();
    drive_slot();
    wp = rp;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n, output int rd_cnt, output int first_rd,
                            output int v_cnt, output int first_v, output int last_v,
                            output int busy_cnt);
    rd_cnt = 0; first_rd = -1; v_cnt = 0; first_v = -1; last_v = -1; busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = i;
        if (bus.fifo_empty) check("rd_en_while_empty", 32'd1, 32'd0);
      end
      if (bus.m_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt, rp0;

    // Reset state
    enable = 1'b1;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_underflow_cnt", {16'd0, underflow_cnt}, 32'd0);

    // Full-rate drain of 8 words
    do_reset();
    for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
    drive_slot();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    run_cycles(14, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t2_rd_cnt", rd_cnt, 32'd8);
    check("t2_first_rd", first_rd, 32'd0);
    check("t2_first_valid", first_v, 32'd2);
    check("t2_valid_cnt", v_cnt, 32'd8);
    check("t2_valid_span", last_v - first_v, 32'd7);
    check("t2_word_cnt", {16'd0, word_cnt}, 32'd8);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    check("t2_scoreboard_empty", exp_q.size(), 32'd0);

    // Backpressure: only two reads in flight, then release
    do_reset();
    for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
    drive_slot();
    enable = 1'b1;
    bus.m_ready = 1'b0;
    run_cycles(10, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t3_stalled_rd_cnt", rd_cnt, 32'd2);
    check("t3_stalled_valid", {31'd0, bus.m_valid}, 32'd1);
    check("t3_stalled_data", {16'd0, bus.m_data}, 32'h0001);
    drive_slot();
    bus.m_ready = 1'b1;
    run_cycles(14, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t3_valid_cnt", v_cnt, 32'd8);
    check("t3_first_valid", first_v, 32'd0);
    check("t3_valid_span", last_v - first_v, 32'd7);
    check("t3_word_cnt", {16'd0, word_cnt}, 32'd8);
    check("t3_scoreboard_empty", exp_q.size(), 32'd0);

    // Empty FIFO: nothing moves
    do_reset();
    drive_slot();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    run_cycles(20, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t4_rd_cnt", rd_cnt, 32'd0);
    check("t4_valid_cnt", v_cnt, 32'd0);
    check("t4_busy_cnt", busy_cnt, 32'd0);

    // Underflow on the second read: word 0x00A2 is discarded
    do_reset();
    uf_idx = wp + 1;
    load(16'h00A1, 1'b1);
    load(16'h00A2, 1'b0);
    load(16'h00A3, 1'b1);
    load(16'h00A4, 1'b1);
    drive_slot();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    run_cycles(12, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t5_rd_cnt", rd_cnt, 32'd4);
    check("t5_valid_cnt", v_cnt, 32'd3);
    check("t5_underflow_cnt", {16'd0, underflow_cnt}, 32'd1);
    check("t5_word_cnt", {16'd0, word_cnt}, 32'd3);
    check("t5_scoreboard_empty", exp_q.size(), 32'd0);

    // Reset with one word buffered and one in flight: both dropped
    do_reset();
    rp0 = rp;
    load(16'h00C1, 1'b0);
    load(16'h00C2, 1'b0);
    load(16'h00C3, 1'b0);
    drive_slot();
    enable = 1'b1;
    bus.m_ready = 1'b0;
    run_cycles(2, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t6_rd_cnt", rd_cnt, 32'd2);
    drive_slot();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rd_en_in_rst", {31'd0, bus.fifo_rd_en}, 32'd0);
    drive_slot();
    rst = 1'b0;
    enable = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", {31'd0, bus.m_valid}, 32'd0);
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    run_cycles(10, rd_cnt, first_rd, v_cnt, first_v, last_v, busy_cnt);
    check("t6_valid_cnt", v_cnt, 32'd0);
    check("t6_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("t6_underflow_cnt", {16'd0, underflow_cnt}, 32'd0);
    check("t6_fifo_reads", rp - rp0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
